// File: rtl/i2c_slave_byte_engine_if.sv
// Bus/handshake bundle of the I2C slave byte engine.
// The slave modport is the engine's view; the master modport is the
// pad/Wishbone-side environment that drives the pins and the byte handshakes.
interface i2c_slave_byte_engine_if;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe_o;
    logic       sda_oe_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_first_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       start_o;
    logic       stop_o;
    logic       rw_o;
    logic       busy_o;

    modport slave (
        input  scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
        output scl_oe_o, sda_oe_o, rx_data_o, rx_valid_o, rx_first_o,
               tx_ready_o, start_o, stop_o, rw_o, busy_o
    );

    modport master (
        output scl_i, sda_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  scl_oe_o, sda_oe_o, rx_data_o, rx_valid_o, rx_first_o,
               tx_ready_o, start_o, stop_o, rw_o, busy_o
    );
endinterface

// File: rtl/i2c_slave_byte_engine.sv
// I2C slave serial front end: synchronises and glitch-filters SCL/SDA,
// detects START/STOP, matches the 7-bit address, ACKs and shifts bytes, and
// exchanges data bytes with the Wishbone side over valid/ready, stretching
// SCL whenever that side has not yet taken or supplied a byte.
module i2c_slave_byte_engine #(
    parameter logic [6:0] SLAVE_ADDR    = 7'h55,
    parameter int         SYNC_STAGES   = 2,
    parameter int         GLITCH_CYCLES = 3
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    i2c_slave_byte_engine_if.slave   bus
);

    localparam int              CNT_W    = $clog2(GLITCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK,
        ST_RD_LOAD, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic [CNT_W-1:0]       scl_cnt_r;
    logic [CNT_W-1:0]       sda_cnt_r;
    logic                   scl_filt_r;
    logic                   sda_filt_r;
    logic                   scl_prev_r;
    logic                   sda_prev_r;
    logic [7:0]             shift_r;
    logic [2:0]             bit_cnt_r;
    logic                   first_r;     // next delivered write byte is the first after the address
    logic                   rx_pend_r;   // received byte waiting for the rx slot to free up

    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;
    logic [7:0] byte_s;
    logic       rx_free_s;

    assign scl_rise_s = scl_filt_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_filt_r & scl_prev_r;
    assign start_s    = scl_filt_r & scl_prev_r & ~sda_filt_r & sda_prev_r;
    assign stop_s     = scl_filt_r & scl_prev_r & sda_filt_r & ~sda_prev_r;
    assign byte_s     = {shift_r[6:0], sda_filt_r};
    assign rx_free_s  = ~bus.rx_valid_o | bus.rx_ready_i;

    // Pad synchronisers, preset to the idle (high) bus level
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scl_sync_r <= '1;
            sda_sync_r <= '1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], bus.sda_i};
        end
    end

    // Glitch filters: a level only flips after GLITCH_CYCLES consecutive differing samples
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
            scl_cnt_r  <= '0;
            sda_cnt_r  <= '0;
        end else begin
            scl_prev_r <= scl_filt_r;
            sda_prev_r <= sda_filt_r;
            if (scl_sync_r[SYNC_STAGES-1] == scl_filt_r) begin
                scl_cnt_r <= '0;
            end else if (scl_cnt_r == CNT_LAST) begin
                scl_filt_r <= ~scl_filt_r;
                scl_cnt_r  <= '0;
            end else begin
                scl_cnt_r <= scl_cnt_r + CNT_ONE;
            end
            if (sda_sync_r[SYNC_STAGES-1] == sda_filt_r) begin
                sda_cnt_r <= '0;
            end else if (sda_cnt_r == CNT_LAST) begin
                sda_filt_r <= ~sda_filt_r;
                sda_cnt_r  <= '0;
            end else begin
                sda_cnt_r <= sda_cnt_r + CNT_ONE;
            end
        end
    end

    // Protocol FSM with registered pin drivers and byte handshakes
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r        <= ST_IDLE;
            shift_r        <= 8'h00;
            bit_cnt_r      <= 3'd0;
            first_r        <= 1'b0;
            rx_pend_r      <= 1'b0;
            bus.scl_oe_o   <= 1'b0;
            bus.sda_oe_o   <= 1'b0;
            bus.rx_data_o  <= 8'h00;
            bus.rx_valid_o <= 1'b0;
            bus.rx_first_o <= 1'b0;
            bus.tx_ready_o <= 1'b0;
            bus.start_o    <= 1'b0;
            bus.stop_o     <= 1'b0;
            bus.rw_o       <= 1'b0;
            bus.busy_o     <= 1'b0;
        end else begin
            bus.start_o <= 1'b0;
            bus.stop_o  <= 1'b0;
            // Completed handshakes retire; a delivery below may re-arm rx_valid
            if (bus.rx_valid_o && bus.rx_ready_i) begin
                bus.rx_valid_o <= 1'b0;
            end
            if (bus.tx_ready_o && bus.tx_valid_i) begin
                bus.tx_ready_o <= 1'b0;
            end

            if (start_s || stop_s) begin
                // Bus conditions abort any byte in flight and free both lines
                bus.scl_oe_o   <= 1'b0;
                bus.sda_oe_o   <= 1'b0;
                bus.tx_ready_o <= 1'b0;
                rx_pend_r      <= 1'b0;
                bit_cnt_r      <= 3'd0;
                bus.start_o    <= start_s;
                bus.stop_o     <= stop_s;
                bus.busy_o     <= start_s;
                state_r        <= start_s ? ST_ADDR : ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                if (byte_s[7:1] == SLAVE_ADDR) begin
                                    bus.rw_o <= byte_s[0];
                                    first_r  <= 1'b1;
                                    state_r  <= ST_ADDR_ACK;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // sda_oe_o doubles as the phase marker: low before the ACK bit, high during it
                        if (scl_fall_s) begin
                            if (!bus.sda_oe_o) begin
                                bus.sda_oe_o <= 1'b1;
                            end else begin
                                bus.sda_oe_o <= 1'b0;
                                bit_cnt_r    <= 3'd0;
                                if (bus.rw_o) begin
                                    bus.tx_ready_o <= 1'b1;
                                    bus.scl_oe_o   <= 1'b1;
                                    state_r        <= ST_RD_LOAD;
                                end else begin
                                    state_r <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                state_r <= ST_WR_ACK;
                                if (rx_free_s) begin
                                    bus.rx_data_o  <= byte_s;
                                    bus.rx_valid_o <= 1'b1;
                                    bus.rx_first_o <= first_r;
                                    first_r        <= 1'b0;
                                end else begin
                                    rx_pend_r <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        // A byte held back by an unaccepted predecessor goes out once the slot frees
                        if (rx_pend_r && rx_free_s) begin
                            bus.rx_data_o  <= shift_r;
                            bus.rx_valid_o <= 1'b1;
                            bus.rx_first_o <= first_r;
                            first_r        <= 1'b0;
                            rx_pend_r      <= 1'b0;
                        end
                        if (scl_fall_s && !bus.sda_oe_o) begin
                            bus.sda_oe_o <= 1'b1;
                        end else if (scl_fall_s) begin
                            bus.sda_oe_o <= 1'b0;
                            bus.scl_oe_o <= 1'b0;
                            bit_cnt_r    <= 3'd0;
                            state_r      <= ST_WR_DATA;
                        end else if (bus.sda_oe_o) begin
                            bus.scl_oe_o <= rx_pend_r | (bus.rx_valid_o & ~bus.rx_ready_i);
                        end
                    end
                    ST_RD_LOAD: begin
                        if (bus.tx_ready_o && bus.tx_valid_i) begin
                            shift_r      <= bus.tx_data_i;
                            bus.sda_oe_o <= ~bus.tx_data_i[7];
                            bus.scl_oe_o <= 1'b0;
                            bit_cnt_r    <= 3'd0;
                            state_r      <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 3'd7) begin
                                bus.sda_oe_o <= 1'b0;
                                state_r      <= ST_RD_ACK;
                            end else begin
                                bus.sda_oe_o <= ~shift_r[6];
                                shift_r      <= {shift_r[6:0], 1'b0};
                                bit_cnt_r    <= bit_cnt_r + 3'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise_s && sda_filt_r) begin
                            state_r <= ST_IGNORE;
                        end else if (scl_fall_s) begin
                            bus.tx_ready_o <= 1'b1;
                            bus.scl_oe_o   <= 1'b1;
                            state_r        <= ST_RD_LOAD;
                        end
                    end
                    ST_IGNORE: begin
                        state_r <= ST_IGNORE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Bench for i2c_slave_byte_engine: a bit-level I2C master drives the wired-AND
// bus, randomised rx/tx handshake drivers feed the byte side, and a monitor
// checks every delivered byte against a scoreboard queue built from the
// transactions the master issues.
module tb_i2c_slave_byte_engine;

    localparam int HALF = 20;

    logic tb_clk = 1'b0;
    logic tb_rst = 1'b1;
    logic m_scl  = 1'b1;
    logic m_sda  = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_rx[$];      // {first, data} expected on the rx port
    logic [7:0] exp_rd[$];      // bytes handed to the engine for reads
    int   start_cnt = 0, stop_cnt = 0, exp_start = 0, exp_stop = 0;
    int   tx_hs_cnt = 0, stretch_cyc = 0, sda_oe_cyc = 0;
    int   rx_mode = 0;          // 0 always ready, 1 random, 2 one-shot 50-cycle stall
    bit   tx_fixed_en = 1'b0;
    logic [7:0] tx_fixed = 8'h00;
    bit   w_acked = 1'b0;       // model: current transfer is an acknowledged write
    bit   first_m = 1'b0;

    i2c_slave_byte_engine_if bus ();

    i2c_slave_byte_engine dut (
        .wb_clk_i (tb_clk),
        .wb_rst_i (tb_rst),
        .bus      (bus)
    );

    assign bus.scl_i = m_scl & ~bus.scl_oe_o;
    assign bus.sda_i = m_sda & ~bus.sda_oe_o;

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (bus.scl_i !== 1'b1 && n < 5000) begin
            cycles(1);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL scl_timeout: SCL low for %0d cycles, required release", n);
        end
    endtask

    task automatic clock_bit(input logic b, output logic r);
        m_sda = b;
        cycles(HALF);
        m_scl = 1'b1;
        wait_scl_high();
        cycles(HALF / 2);
        r = bus.sda_i;
        cycles(HALF / 2);
        m_scl = 1'b0;
        cycles(HALF);
    endtask

    task automatic send_start();
        m_sda = 1'b1;
        cycles(HALF);
        m_scl = 1'b1;
        wait_scl_high();
        cycles(HALF);
        m_sda = 1'b0;
        cycles(HALF);
        m_scl = 1'b0;
        cycles(HALF);
        exp_start++;
        w_acked = 1'b0;
    endtask

    task automatic send_stop();
        m_sda = 1'b0;
        cycles(HALF);
        m_scl = 1'b1;
        wait_scl_high();
        cycles(HALF);
        m_sda = 1'b1;
        cycles(HALF);
        exp_stop++;
        w_acked = 1'b0;
    endtask

    task automatic send_addr(input logic [7:0] a);
        logic r;
        logic ack;
        logic exp_ack;
        for (int i = 7; i >= 0; i--) clock_bit(a[i], r);
        clock_bit(1'b1, ack);
        exp_ack = (a[7:1] == 7'h55) ? 1'b0 : 1'b1;
        check("addr_ack", ack, exp_ack);
        if (exp_ack == 1'b0) check("rw_bit", bus.rw_o, a[0]);
        w_acked = (exp_ack == 1'b0) && (a[0] == 1'b0);
        first_m = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        logic r;
        logic ack;
        if (w_acked) begin
            exp_rx.push_back({first_m, d});
            first_m = 1'b0;
        end
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, ack);
        check("wr_ack", ack, w_acked ? 1'b0 : 1'b1);
    endtask

    task automatic read_byte(input logic last, output logic [7:0] got);
        logic r;
        logic [7:0] e;
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, r);
            got = {got[6:0], r};
        end
        clock_bit(last, r);
        if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_data: got %0h with no byte supplied", got);
        end else begin
            e = exp_rd.pop_front();
            check("rd_data", got, e);
        end
    endtask

    task automatic drain_rx();
        int n = 0;
        while (exp_rx.size() != 0 && n < 3000) begin
            cycles(1);
            n++;
        end
        check("rx_drained", exp_rx.size(), 0);
    endtask

    // rx_ready driver
    initial begin
        bus.rx_ready_i = 1'b1;
        forever begin
            @(posedge tb_clk);
            #1;
            case (rx_mode)
                0: bus.rx_ready_i = 1'b1;
                1: bus.rx_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    bus.rx_ready_i = 1'b0;
                    if (bus.scl_oe_o) begin
                        repeat (50) @(posedge tb_clk);
                        #1;
                        bus.rx_ready_i = 1'b1;
                        rx_mode = 0;
                    end
                end
                default: bus.rx_ready_i = 1'b1;
            endcase
        end
    end

    // tx driver: answers tx_ready_o after a random delay and records the byte supplied
    initial begin
        logic [7:0] d;
        bus.tx_valid_i = 1'b0;
        bus.tx_data_i  = 8'h00;
        forever begin
            @(posedge tb_clk);
            #1;
            if (bus.tx_ready_o) begin
                repeat ($urandom_range(0, 5)) @(posedge tb_clk);
                #1;
                if (bus.tx_ready_o) begin
                    d = tx_fixed_en ? tx_fixed : 8'($urandom);
                    bus.tx_data_i  = d;
                    bus.tx_valid_i = 1'b1;
                    exp_rd.push_back(d);
                    @(posedge tb_clk);
                    #1;
                    bus.tx_valid_i = 1'b0;
                end
            end
        end
    end

    // Output monitor: rx scoreboard, event pulses, stretch and drive statistics
    initial begin
        logic [8:0] e;
        logic       start_prev = 1'b0, stop_prev = 1'b0;
        logic       prev_valid = 1'b0, prev_ready = 1'b0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge tb_clk);
            if (bus.rx_valid_o && bus.rx_ready_i) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx: got %0h with none expected", bus.rx_data_o);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_byte", {bus.rx_first_o, bus.rx_data_o}, e);
                end
            end
            if (prev_valid && !prev_ready && bus.rx_valid_o) check("rx_hold", bus.rx_data_o, prev_data);
            if (bus.start_o) begin
                start_cnt++;
                check("start_width", start_prev, 1'b0);
            end
            if (bus.stop_o) begin
                stop_cnt++;
                check("stop_width", stop_prev, 1'b0);
            end
            if (bus.tx_ready_o && bus.tx_valid_i) tx_hs_cnt++;
            if (bus.scl_oe_o) stretch_cyc++;
            if (bus.sda_oe_o) sda_oe_cyc++;
            start_prev = bus.start_o;
            stop_prev  = bus.stop_o;
            prev_valid = bus.rx_valid_o;
            prev_ready = bus.rx_ready_i;
            prev_data  = bus.rx_data_o;
        end
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded 90000 cycles");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        logic [7:0] got;
        logic [7:0] a;
        logic       r;
        int         base, nb;

        cycles(5);
        check("reset_outputs", {bus.scl_oe_o, bus.sda_oe_o, bus.rx_data_o, bus.rx_valid_o,
                                bus.rx_first_o, bus.tx_ready_o, bus.start_o, bus.stop_o,
                                bus.rw_o, bus.busy_o}, 32'd0);
        tb_rst = 1'b0;
        cycles(5);
        check("idle_busy", bus.busy_o, 1'b0);

        // Plain write of two bytes
        rx_mode = 0;
        send_start();
        check("busy_after_start", bus.busy_o, 1'b1);
        send_addr(8'hAA);
        write_byte(8'h3C);
        write_byte(8'h5A);
        send_stop();
        cycles(10);
        check("busy_after_stop", bus.busy_o, 1'b0);
        drain_rx();
        check("start_count", start_cnt, exp_start);
        check("stop_count", stop_cnt, exp_stop);

        // Write with a 50-cycle stall on the first byte
        rx_mode = 2;
        stretch_cyc = 0;
        send_start();
        send_addr(8'hAA);
        write_byte(8'h3C);
        write_byte(8'h5A);
        send_stop();
        drain_rx();
        checks++;
        if (stretch_cyc < 45 || stretch_cyc > 60) begin
            errors++;
            $display("FAIL stretch_len: got %0d cycles required 45..60", stretch_cyc);
        end

        // Non-matching address
        rx_mode = 0;
        sda_oe_cyc = 0;
        send_start();
        send_addr(8'h00);
        check("nack_busy", bus.busy_o, 1'b1);
        check("nack_no_rx", bus.rx_valid_o, 1'b0);
        send_stop();
        cycles(10);
        check("nack_busy_end", bus.busy_o, 1'b0);
        check("nack_sda_quiet", sda_oe_cyc, 0);

        // Read 0xC3, master NACKs
        tx_fixed_en = 1'b1;
        tx_fixed = 8'hC3;
        base = tx_hs_cnt;
        send_start();
        send_addr(8'hAB);
        read_byte(1'b1, got);
        check("read_c3", got, 8'hC3);
        cycles(100);
        check("tx_ready_after_nack", bus.tx_ready_o, 1'b0);
        check("tx_handshakes", tx_hs_cnt - base, 1);
        send_stop();
        tx_fixed_en = 1'b0;

        // Repeated START after four bits of a data byte
        send_start();
        send_addr(8'hAA);
        for (int i = 0; i < 4; i++) clock_bit(i[0], r);
        send_start();
        send_addr(8'hAA);
        write_byte(8'h77);
        send_stop();
        drain_rx();
        check("restart_starts", start_cnt, exp_start);

        // Two-cycle SCL glitch before the address must not shift a bit
        send_start();
        m_scl = 1'b1;
        cycles(2);
        m_scl = 1'b0;
        cycles(HALF);
        send_addr(8'hAA);
        write_byte(8'h96);
        send_stop();
        drain_rx();

        // Reset in the middle of a read
        tx_fixed_en = 1'b1;
        tx_fixed = 8'h00;
        send_start();
        send_addr(8'hAB);
        clock_bit(1'b1, r);
        clock_bit(1'b1, r);
        check("read_drive_low", bus.sda_oe_o, 1'b1);
        tb_rst = 1'b1;
        cycles(1);
        check("reset_release", {bus.scl_oe_o, bus.sda_oe_o, bus.busy_o}, 3'b000);
        tb_rst = 1'b0;
        exp_rd.delete();
        tx_fixed_en = 1'b0;
        m_sda = 1'b0;
        cycles(HALF);
        m_scl = 1'b1;
        cycles(HALF);
        m_sda = 1'b1;
        cycles(HALF);
        exp_stop++;
        check("stop_after_reset", stop_cnt, exp_stop);

        // Randomised mix of reads and writes with random rx back-pressure
        rx_mode = 1;
        for (int t = 0; t < 8; t++) begin
            nb = $urandom_range(1, 3);
            send_start();
            if ($urandom_range(0, 2) == 0) begin
                send_addr(8'hAB);
                for (int k = 0; k < nb; k++) read_byte(k == nb - 1, got);
            end else begin
                a = ($urandom_range(0, 2) != 0) ? 8'hAA : 8'($urandom);
                if (a[7:1] == 7'h55) a = 8'hAA;
                send_addr(a);
                if (w_acked) begin
                    for (int k = 0; k < nb; k++) write_byte(8'($urandom));
                end
            end
            send_stop();
        end
        drain_rx();
        check("final_starts", start_cnt, exp_start);
        check("final_stops", stop_cnt, exp_stop);
        check("final_busy", bus.busy_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
